// File: rtl/sixteen_bit_adder_rtl.sv
// Registered BITS-wide ripple-carry adder with carry-in/carry-out and a valid flag.
// Define SIXTEEN_BIT_ADDER_OVF_EN to add the registered signed Overflow output.
module sixteen_bit_adder_rtl #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic            CarryIN,
    input  logic            InValid,
    output logic [BITS-1:0] Sum,
    output logic            CarryOUT,
    output logic            OutValid
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
    ,
    output logic            Overflow
`endif
);

    logic [BITS:0]   carry_s;
    logic [BITS-1:0] sum_s;

    // Full-adder chain; carry_s[i] is the carry into bit i.
    always_comb begin
        carry_s    = '0;
        sum_s      = '0;
        carry_s[0] = CarryIN;
        for (int i = 0; i < BITS; i++) begin
            sum_s[i]       = A[i] ^ B[i] ^ carry_s[i];
            carry_s[i+1]   = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
        end
    end

    // Result register: captures on valid input, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum      <= '0;
            CarryOUT <= 1'b0;
            OutValid <= 1'b0;
        end else begin
            OutValid <= InValid;
            if (InValid) begin
                Sum      <= sum_s;
                CarryOUT <= carry_s[BITS];
            end else begin
                Sum      <= Sum;
                CarryOUT <= CarryOUT;
            end
        end
    end

`ifdef SIXTEEN_BIT_ADDER_OVF_EN
    // Signed overflow: carries into and out of the sign bit disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Overflow <= 1'b0;
        end else if (InValid) begin
            Overflow <= carry_s[BITS] ^ carry_s[BITS-1];
        end else begin
            Overflow <= Overflow;
        end
    end
`endif

endmodule

// File: tb/tb_sixteen_bit_adder_rtl.sv
// Scoreboard bench for sixteen_bit_adder_rtl: directed corners, hold, reset, and byte sweeps.
module tb_sixteen_bit_adder_rtl;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        in_valid;
    logic [15:0] sum;
    logic        carry_out;
    logic        out_valid;
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
    logic        overflow;
`endif

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_r;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    sixteen_bit_adder_rtl #(.BITS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (a),
        .B        (b),
        .CarryIN  (carry_in),
        .InValid  (in_valid),
        .Sum      (sum),
        .CarryOUT (carry_out),
        .OutValid (out_valid)
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
        ,
        .Overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", chk_cnt);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: 17-bit integer add, signed overflow from operand/result signs.
    function automatic exp_t ref_add(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [16:0] t;
        exp_t        e;
        t   = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        e.s = t[15:0];
        e.c = t[16];
        e.o = (x[15] == y[15]) && (t[15] != x[15]);
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, "_sum"}, {16'd0, sum}, {16'd0, last_r.s});
        check_val({tag, "_cout"}, {31'd0, carry_out}, {31'd0, last_r.c});
`ifdef SIXTEEN_BIT_ADDER_OVF_EN
        check_val({tag, "_ovf"}, {31'd0, overflow}, {31'd0, last_r.o});
`endif
    endtask

    task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic v);
        a        = x;
        b        = y;
        carry_in = ci;
        in_valid = v;
        if (v) sb_q.push_back(ref_add(x, y, ci));
        @(posedge clk);
        #1;
        // Scramble inputs between edges; only sampled values may matter.
        a        = ~x;
        b        = ~y;
        carry_in = ~ci;
        check_val({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) last_r = sb_q.pop_front();
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_outputs(tag);
    endtask

    initial begin
        clk_en   = 1'b0;
        rst      = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        carry_in = 1'b0;
        in_valid = 1'b0;
        last_r   = '0;

        // Asynchronous reset with clock idle.
        #3 rst = 1'b1;
        #1 check_reset_state("rst_async");
        #5 rst = 1'b0;
        clk_en = 1'b1;

        step("basic", 16'h1234, 16'h4321, 1'b0, 1'b1);
        step("wrap0", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        step("wrap1", 16'hFFFF, 16'h0001, 1'b1, 1'b1);
        step("allone", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        step("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b1);
        step("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        step("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b1);
        step("mixed", 16'hA5A5, 16'h5A5A, 1'b1, 1'b1);

        // Hold while InValid is low.
        for (int i = 0; i < 3; i++) step("hold", 16'h0F0F + 16'(i), 16'h1111, 1'b1, 1'b0);

        // Reset mid-stream discards an in-flight valid sample.
        a        = 16'h2222;
        b        = 16'h3333;
        carry_in = 1'b0;
        in_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        sb_q.delete();
        last_r = '0;
        check_reset_state("rst_mid");
        @(posedge clk);
        #1 check_reset_state("rst_held");
        rst      = 1'b0;
        step("post_rst_idle", 16'h4444, 16'h5555, 1'b0, 1'b0);
        step("post_rst_first", 16'h4444, 16'h5555, 1'b0, 1'b1);

        // Low-byte sweeps with upper byte 00 and FF, both carry-in values.
        for (int hi = 0; hi < 2; hi++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int i = 0; i < 256; i++) begin
                    for (int j = 0; j < 16; j++) begin
                        logic [15:0] xa;
                        logic [15:0] xb;
                        xa = {(hi != 0) ? 8'hFF : 8'h00, 8'(i)};
                        xb = {(hi != 0) ? 8'hFF : 8'h00, 8'(j * 17)};
                        step("sweep", xa, xb, 1'(ci), 1'b1);
                    end
                end
            end
        end

        // Random traffic with sporadic idle cycles.
        for (int i = 0; i < 200; i++) begin
            step("rand", 16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
